bus_dest_regs: RTL and testbench
================================

Name: bus_dest_regs

Overview:
Write-side counterpart of the processor's read-side bus multiplexer. It captures the 24-bit shared bus into one or more destination registers selected by a write-enable mask, and provides register increments and an AC clear. It also registers a data-memory write strobe. Its register outputs are the sources the read-side bus multiplexer drives onto the bus.

Parameters:
BUS_WIDTH, 24, width of shared bus input
DM_WIDTH, 8, data-memory word width
WE_WIDTH, 16, width of write-enable mask

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
bus_in  input  BUS_WIDTH  current bus value (busout of read-side mux)
write_en  input  WE_WIDTH  one bit per destination, several may be set together
inc_en  input  5  increment mask: [0] pc, [1] ar, [2] x, [3] y, [4] z
clr_ac  input  1  synchronous clear of ac
pc  output  16  program counter
ir  output  16  instruction register
ar  output  16  address register
ac  output  24  accumulator
x, y, z  output  8 each  matrix index registers
stxy, styz, stxz  output  16 each  stride/start registers
r  output  16  general register
r1  output  8  general register
r2  output  24  general register
r3  output  16  general register
dm_we  output  1  data-memory write strobe, one cycle
dm_wdata  output  DM_WIDTH  data-memory write data
ac_zero  output  1  high when ac == 0 (combinational from ac)

Behaviour:
- Reset: asynchronous and active-high. When asserted, all registers, dm_we and dm_wdata go to 0 immediately; ac_zero = 1. Reset mid-operation discards any pending load or increment.
- write_en bit map:
  - 0 pc, 1 ir, 2 ar, 3 ac, 4 x, 5 y, 6 z
  - 7 stxy, 8 styz, 9 stxz
  - 10 r, 11 r1, 12 r2, 13 r3
  - 14 data-memory write
  - 15 reserved, ignored
- Load: on the rising edge with the write_en bit set, the register takes bus_in[W-1:0], where W is its width. Upper bus bits are discarded. Load latency is 1 cycle; the new value is visible the cycle after the enable.
- Multiple write_en bits set: every selected register loads the same bus value in the same cycle.
- Increment: an inc_en bit adds 1 modulo 2^W. Wrap-around is required: pc 0xFFFF -> 0x0000, x 0xFF -> 0x00.
- Per-register priority: load beats increment. With write_en[0] and inc_en[0] both set, pc = bus_in[15:0], not bus_in + 1.
- AC priority: clr_ac beats write_en[3]. clr_ac sets ac to 0.
- Hold: a register with no enable holds its value.
- Data-memory write: write_en[14] causes dm_we = 1 and dm_wdata = bus_in[7:0] on the next cycle. dm_we returns to 0 the following cycle unless write_en[14] is held. With write_en[14] held for N cycles, dm_we stays high for N cycles, lagging by one cycle. dm_wdata holds its last value when dm_we = 0.
- No internal FSM beyond per-register next-state logic. Fully synchronous except reset.

Decomposition:
- Shared package: write_en bit-index constants (WE_PC … WE_DM), inc_en bit indices, register width constants, BUS_WIDTH.
- The read-side bus multiplexer uses the same package so select codes and destination map stay in one place.
- One sub-module, bus_dest_reg. It is parameterised by width and has load, inc and clr inputs, with priority clr > load > inc. It is instantiated once per destination.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after loading pc = 0x1234 -> all outputs 0 immediately, ac_zero = 1.
- Truncation: bus_in = 0xABCDEF with write_en bits 0, 4 and 12 set -> next cycle pc = 0xCDEF, x = 0xEF, r2 = 0xABCDEF; all other registers unchanged.
- Increment and wrap: load pc = 0xFFFE, then hold inc_en[0] for 2 cycles -> pc = 0xFFFF, then 0x0000. Load z = 0xFF, then inc_en[4] -> z = 0x00.
- Priority: pc = 0x0010 with write_en[0], inc_en[0] and bus_in = 0x000500 in the same cycle -> pc = 0x0500. clr_ac with write_en[3] and bus_in = 0x000016 -> ac = 0, ac_zero = 1.
- Data-memory strobe: write_en[14] for 1 cycle with bus_in = 0x000116 -> dm_we high for exactly the next cycle, dm_wdata = 0x16. Held for 3 cycles -> dm_we high for 3 cycles, one-cycle lag.
- Load/hold sequence: one register per cycle (pc, ir, ar, ac, x) with bus_in = 16 -> each reads 16 from the cycle after its enable and holds while the others load.

Source files
------------

// File: rtl/bus_dest_regs_pkg.sv
// rtl/bus_dest_regs_pkg.sv - destination map, enable bit indices and register widths
package bus_dest_regs_pkg;

    localparam int BUS_WIDTH = 24;
    localparam int DM_WIDTH  = 8;
    localparam int WE_WIDTH  = 16;
    localparam int INC_WIDTH = 5;

    // write_en bit indices
    localparam int WE_PC   = 0;
    localparam int WE_IR   = 1;
    localparam int WE_AR   = 2;
    localparam int WE_AC   = 3;
    localparam int WE_X    = 4;
    localparam int WE_Y    = 5;
    localparam int WE_Z    = 6;
    localparam int WE_STXY = 7;
    localparam int WE_STYZ = 8;
    localparam int WE_STXZ = 9;
    localparam int WE_R    = 10;
    localparam int WE_R1   = 11;
    localparam int WE_R2   = 12;
    localparam int WE_R3   = 13;
    localparam int WE_DM   = 14;
    localparam int WE_RSVD = 15;

    // inc_en bit indices
    localparam int INC_PC = 0;
    localparam int INC_AR = 1;
    localparam int INC_X  = 2;
    localparam int INC_Y  = 3;
    localparam int INC_Z  = 4;

    // register widths
    localparam int PC_W   = 16;
    localparam int IR_W   = 16;
    localparam int AR_W   = 16;
    localparam int AC_W   = 24;
    localparam int IDX_W  = 8;
    localparam int ST_W   = 16;
    localparam int R_W    = 16;
    localparam int R1_W   = 8;
    localparam int R2_W   = 24;
    localparam int R3_W   = 16;

    function automatic logic [WE_WIDTH-1:0] we_bit(input int idx);
        logic [WE_WIDTH-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/bus_dest_regs_if.sv
// rtl/bus_dest_regs_if.sv - bus capture controls in, destination register values out
interface bus_dest_regs_if;
    import bus_dest_regs_pkg::*;

    logic [BUS_WIDTH-1:0] bus_in;
    logic [WE_WIDTH-1:0]  write_en;
    logic [INC_WIDTH-1:0] inc_en;
    logic                 clr_ac;

    logic [PC_W-1:0]      pc;
    logic [IR_W-1:0]      ir;
    logic [AR_W-1:0]      ar;
    logic [AC_W-1:0]      ac;
    logic [IDX_W-1:0]     x;
    logic [IDX_W-1:0]     y;
    logic [IDX_W-1:0]     z;
    logic [ST_W-1:0]      stxy;
    logic [ST_W-1:0]      styz;
    logic [ST_W-1:0]      stxz;
    logic [R_W-1:0]       r;
    logic [R1_W-1:0]      r1;
    logic [R2_W-1:0]      r2;
    logic [R3_W-1:0]      r3;
    logic                 dm_we;
    logic [DM_WIDTH-1:0]  dm_wdata;
    logic                 ac_zero;

    modport master (
        output bus_in, write_en, inc_en, clr_ac,
        input  pc, ir, ar, ac, x, y, z, stxy, styz, stxz,
               r, r1, r2, r3, dm_we, dm_wdata, ac_zero
    );

    modport slave (
        input  bus_in, write_en, inc_en, clr_ac,
        output pc, ir, ar, ac, x, y, z, stxy, styz, stxz,
               r, r1, r2, r3, dm_we, dm_wdata, ac_zero
    );

endinterface

// File: rtl/bus_dest_regs_reg.sv
// rtl/bus_dest_regs_reg.sv - one destination register with clr > load > inc priority
module bus_dest_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bus_dest_regs.sv
// rtl/bus_dest_regs.sv - captures the shared bus into write_en-selected destination registers
module bus_dest_regs
    import bus_dest_regs_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    bus_dest_regs_if.slave  bus
);

    logic [PC_W-1:0]     pc_q;
    logic [IR_W-1:0]     ir_q;
    logic [AR_W-1:0]     ar_q;
    logic [AC_W-1:0]     ac_q;
    logic [IDX_W-1:0]    x_q;
    logic [IDX_W-1:0]    y_q;
    logic [IDX_W-1:0]    z_q;
    logic [ST_W-1:0]     stxy_q;
    logic [ST_W-1:0]     styz_q;
    logic [ST_W-1:0]     stxz_q;
    logic [R_W-1:0]      r_q;
    logic [R1_W-1:0]     r1_q;
    logic [R2_W-1:0]     r2_q;
    logic [R3_W-1:0]     r3_q;
    logic                dm_we_q;
    logic [DM_WIDTH-1:0] dm_wdata_q;

    logic                unused_we_rsvd;
    assign unused_we_rsvd = bus.write_en[WE_RSVD];

    bus_dest_reg #(.WIDTH(PC_W)) u_pc (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_PC]), .inc(bus.inc_en[INC_PC]),
        .d(bus.bus_in[PC_W-1:0]), .q(pc_q)
    );

    bus_dest_reg #(.WIDTH(IR_W)) u_ir (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_IR]), .inc(1'b0),
        .d(bus.bus_in[IR_W-1:0]), .q(ir_q)
    );

    bus_dest_reg #(.WIDTH(AR_W)) u_ar (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_AR]), .inc(bus.inc_en[INC_AR]),
        .d(bus.bus_in[AR_W-1:0]), .q(ar_q)
    );

    // Only ac has a clear; it outranks a simultaneous bus load.
    bus_dest_reg #(.WIDTH(AC_W)) u_ac (
        .clk(clk), .rst(rst), .clr(bus.clr_ac),
        .load(bus.write_en[WE_AC]), .inc(1'b0),
        .d(bus.bus_in[AC_W-1:0]), .q(ac_q)
    );

    bus_dest_reg #(.WIDTH(IDX_W)) u_x (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_X]), .inc(bus.inc_en[INC_X]),
        .d(bus.bus_in[IDX_W-1:0]), .q(x_q)
    );

    bus_dest_reg #(.WIDTH(IDX_W)) u_y (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_Y]), .inc(bus.inc_en[INC_Y]),
        .d(bus.bus_in[IDX_W-1:0]), .q(y_q)
    );

    bus_dest_reg #(.WIDTH(IDX_W)) u_z (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_Z]), .inc(bus.inc_en[INC_Z]),
        .d(bus.bus_in[IDX_W-1:0]), .q(z_q)
    );

    bus_dest_reg #(.WIDTH(ST_W)) u_stxy (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_STXY]), .inc(1'b0),
        .d(bus.bus_in[ST_W-1:0]), .q(stxy_q)
    );

    bus_dest_reg #(.WIDTH(ST_W)) u_styz (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_STYZ]), .inc(1'b0),
        .d(bus.bus_in[ST_W-1:0]), .q(styz_q)
    );

    bus_dest_reg #(.WIDTH(ST_W)) u_stxz (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_STXZ]), .inc(1'b0),
        .d(bus.bus_in[ST_W-1:0]), .q(stxz_q)
    );

    bus_dest_reg #(.WIDTH(R_W)) u_r (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_R]), .inc(1'b0),
        .d(bus.bus_in[R_W-1:0]), .q(r_q)
    );

    bus_dest_reg #(.WIDTH(R1_W)) u_r1 (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_R1]), .inc(1'b0),
        .d(bus.bus_in[R1_W-1:0]), .q(r1_q)
    );

    bus_dest_reg #(.WIDTH(R2_W)) u_r2 (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_R2]), .inc(1'b0),
        .d(bus.bus_in[R2_W-1:0]), .q(r2_q)
    );

    bus_dest_reg #(.WIDTH(R3_W)) u_r3 (
        .clk(clk), .rst(rst), .clr(1'b0),
        .load(bus.write_en[WE_R3]), .inc(1'b0),
        .d(bus.bus_in[R3_W-1:0]), .q(r3_q)
    );

    // Strobe follows write_en[WE_DM] by one cycle; data is held between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_we_q    <= 1'b0;
            dm_wdata_q <= '0;
        end else begin
            dm_we_q <= bus.write_en[WE_DM];
            if (bus.write_en[WE_DM]) begin
                dm_wdata_q <= bus.bus_in[DM_WIDTH-1:0];
            end
        end
    end

    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ar       = ar_q;
    assign bus.ac       = ac_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.z        = z_q;
    assign bus.stxy     = stxy_q;
    assign bus.styz     = styz_q;
    assign bus.stxz     = stxz_q;
    assign bus.r        = r_q;
    assign bus.r1       = r1_q;
    assign bus.r2       = r2_q;
    assign bus.r3       = r3_q;
    assign bus.dm_we    = dm_we_q;
    assign bus.dm_wdata = dm_wdata_q;
    assign bus.ac_zero  = (ac_q == '0);

endmodule

// File: tb/tb_bus_dest_regs.sv
// tb/tb_bus_dest_regs.sv - table-driven scoreboard bench for bus_dest_regs
module tb_bus_dest_regs;

    logic clk;
    logic rst;

    bus_dest_regs_if bif ();

    bus_dest_regs dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        S_PC, S_IR, S_AR, S_AC, S_X, S_Y, S_Z, S_STXY, S_STYZ, S_STXZ,
        S_R, S_R1, S_R2, S_R3, S_DMWE, S_DMWD, S_ACZ, S_NUM
    } sel_t;

    typedef struct {
        logic [23:0] bus_in;
        logic [15:0] write_en;
        logic [4:0]  inc_en;
        logic        clr_ac;
        sel_t        sel;
        logic [23:0] exp;
        int          id;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   row_id   = 0;

    function automatic logic [23:0] get_out(input sel_t s);
        case (s)
            S_PC:   return {8'h0, bif.pc};
            S_IR:   return {8'h0, bif.ir};
            S_AR:   return {8'h0, bif.ar};
            S_AC:   return bif.ac;
            S_X:    return {16'h0, bif.x};
            S_Y:    return {16'h0, bif.y};
            S_Z:    return {16'h0, bif.z};
            S_STXY: return {8'h0, bif.stxy};
            S_STYZ: return {8'h0, bif.styz};
            S_STXZ: return {8'h0, bif.stxz};
            S_R:    return {8'h0, bif.r};
            S_R1:   return {16'h0, bif.r1};
            S_R2:   return bif.r2;
            S_R3:   return {8'h0, bif.r3};
            S_DMWE: return {23'h0, bif.dm_we};
            S_DMWD: return {16'h0, bif.dm_wdata};
            S_ACZ:  return {23'h0, bif.ac_zero};
            default: return 24'hDEAD;
        endcase
    endfunction

    function automatic vec_t mk(input logic [23:0] b, input logic [15:0] we,
                                input logic [4:0] inc, input logic clr,
                                input sel_t s, input logic [23:0] e);
        vec_t v;
        v.bus_in = b; v.write_en = we; v.inc_en = inc; v.clr_ac = clr;
        v.sel = s; v.exp = e; v.id = row_id;
        row_id++;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [23:0] act,
                         input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, id, act, exp);
        end
    endtask

    task automatic flush_one();
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.sel.name(), e.id, get_out(e.sel), e.exp);
        end
    endtask

    task automatic drive_idle();
        bif.bus_in = '0; bif.write_en = '0; bif.inc_en = '0; bif.clr_ac = 1'b0;
    endtask

    // Compare the previous row's result, then drive this row and queue its expectation.
    task automatic apply(input vec_t v);
        @(negedge clk);
        flush_one();
        bif.bus_in = v.bus_in; bif.write_en = v.write_en;
        bif.inc_en = v.inc_en; bif.clr_ac = v.clr_ac;
        sb.push_back(v);
    endtask

    task automatic drain();
        @(negedge clk);
        flush_one();
        drive_idle();
    endtask

    task automatic check_all_reset(input string tag);
        for (int s = 0; s < int'(S_NUM); s++) begin
            check(tag, s, get_out(sel_t'(s)), (sel_t'(s) == S_ACZ) ? 24'h1 : 24'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check_all_reset("reset_state");
        rst = 1'b0;

        // truncation of a multi-destination load, others unchanged
        vecs.push_back(mk(24'hABCDEF, 16'h1011, 5'h00, 1'b0, S_PC,   24'h00CDEF));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_X,    24'h0000EF));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_R2,   24'hABCDEF));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_IR,   24'h000000));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_R1,   24'h000000));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_ACZ,  24'h000001));
        // increment and wrap
        vecs.push_back(mk(24'h00FFFE, 16'h0001, 5'h00, 1'b0, S_PC,   24'h00FFFE));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h01, 1'b0, S_PC,   24'h00FFFF));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h01, 1'b0, S_PC,   24'h000000));
        vecs.push_back(mk(24'h0000FF, 16'h0040, 5'h00, 1'b0, S_Z,    24'h0000FF));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h10, 1'b0, S_Z,    24'h000000));
        // priorities
        vecs.push_back(mk(24'h000010, 16'h0001, 5'h00, 1'b0, S_PC,   24'h000010));
        vecs.push_back(mk(24'h000500, 16'h0001, 5'h01, 1'b0, S_PC,   24'h000500));
        vecs.push_back(mk(24'h000016, 16'h0008, 5'h00, 1'b0, S_AC,   24'h000016));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_ACZ,  24'h000000));
        vecs.push_back(mk(24'h000016, 16'h0008, 5'h00, 1'b1, S_AC,   24'h000000));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_ACZ,  24'h000001));
        // single-cycle data-memory strobe
        vecs.push_back(mk(24'h000116, 16'h4000, 5'h00, 1'b0, S_DMWE, 24'h000001));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_DMWE, 24'h000000));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_DMWD, 24'h000016));
        // one register per cycle, earlier ones hold
        vecs.push_back(mk(24'h000010, 16'h0001, 5'h00, 1'b0, S_PC,   24'h000010));
        vecs.push_back(mk(24'h000010, 16'h0002, 5'h00, 1'b0, S_IR,   24'h000010));
        vecs.push_back(mk(24'h000010, 16'h0004, 5'h00, 1'b0, S_AR,   24'h000010));
        vecs.push_back(mk(24'h000010, 16'h0008, 5'h00, 1'b0, S_AC,   24'h000010));
        vecs.push_back(mk(24'h000010, 16'h0010, 5'h00, 1'b0, S_X,    24'h000010));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_PC,   24'h000010));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_AR,   24'h000010));
        // remaining increments, loads and reserved bit
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h04, 1'b0, S_X,    24'h000011));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h08, 1'b0, S_Y,    24'h000001));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h02, 1'b0, S_AR,   24'h000011));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_PC,   24'h000010));
        vecs.push_back(mk(24'h123456, 16'hA080, 5'h00, 1'b0, S_STXY, 24'h003456));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_R3,   24'h003456));
        vecs.push_back(mk(24'h0000AB, 16'h0800, 5'h00, 1'b0, S_R1,   24'h0000AB));
        vecs.push_back(mk(24'hFEDCBA, 16'h0700, 5'h00, 1'b0, S_STYZ, 24'h00DCBA));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_STXZ, 24'h00DCBA));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_R,    24'h00DCBA));
        vecs.push_back(mk(24'h0000FF, 16'h0010, 5'h00, 1'b0, S_X,    24'h0000FF));
        vecs.push_back(mk(24'h000000, 16'h0000, 5'h04, 1'b0, S_X,    24'h000000));

        foreach (vecs[i]) apply(vecs[i]);
        drain();

        // data-memory write held for three cycles
        apply(mk(24'h000021, 16'h4000, 5'h00, 1'b0, S_DMWE, 24'h000001));
        apply(mk(24'h000022, 16'h4000, 5'h00, 1'b0, S_DMWD, 24'h000022));
        apply(mk(24'h000023, 16'h4000, 5'h00, 1'b0, S_DMWE, 24'h000001));
        apply(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_DMWE, 24'h000000));
        apply(mk(24'h000000, 16'h0000, 5'h00, 1'b0, S_DMWD, 24'h000023));
        drain();

        // asynchronous reset mid-cycle after loading pc
        apply(mk(24'h001234, 16'h0001, 5'h00, 1'b0, S_PC, 24'h001234));
        drain();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_reset("async_reset");
        @(negedge clk);
        rst = 1'b0;

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
